// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, shadow-slot types and forwarding select helper for hazard_unit.
package hazard_pkg;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       load;
    } ex_slot_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } wb_slot_t;

    // M has priority over W; a write to x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input wb_slot_t m, input wb_slot_t w);
        return (m.reg_write && m.rd != REG_ZERO && m.rd == rs) ? FWD_MEM :
               (w.reg_write && w.rd != REG_ZERO && w.rd == rs) ? FWD_WB : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one shadow pipeline slot with sync active-low reset and sync clear.
module hazard_stage_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk)
        q <= (!reset || clear) ? '0 : d;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush, E-stage forwarding and saturating event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    ex_slot_t e_d, e_q;
    wb_slot_t m_d, m_q, w_q;
    logic     lw_stall;

    assign e_d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, reg_write: RegWriteD,
                   load: ResultSrcD == RESULT_SRC_LOAD};
    assign m_d = '{rd: e_q.rd, reg_write: e_q.reg_write};

    hazard_stage_reg #(.W($bits(ex_slot_t))) u_e (
        .clk(clk), .reset(reset), .clear(FlushE), .d(e_d), .q(e_q)
    );
    hazard_stage_reg #(.W($bits(wb_slot_t))) u_m (
        .clk(clk), .reset(reset), .clear(1'b0), .d(m_d), .q(m_q)
    );
    hazard_stage_reg #(.W($bits(wb_slot_t))) u_w (
        .clk(clk), .reset(reset), .clear(1'b0), .d(m_q), .q(w_q)
    );

    always_comb begin
        lw_stall  = e_q.load && e_q.reg_write && e_q.rd != REG_ZERO &&
                    (e_q.rd == Rs1D || e_q.rd == Rs2D);
        StallF    = lw_stall && !PCSrcE;
        StallD    = StallF;
        FlushD    = PCSrcE;
        FlushE    = lw_stall || PCSrcE;
        ForwardAE = fwd_sel(e_q.rs1, m_q, w_q);
        ForwardBE = fwd_sel(e_q.rs2, m_q, w_q);
    end

    always_ff @(posedge clk)
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && !(&StallCount)) StallCount <= StallCount + CNT_W'(1);
            if (PCSrcE && !(&FlushCount)) FlushCount <= FlushCount + CNT_W'(1);
        end

endmodule
